pwm_ramp_ctrl: RTL and testbench



---
 rtl/pwm_ramp_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Channel configuration bus arbiter: forwards host writes one cycle later and
// soft-starts a single channel by stepping its high-level count toward a target.
module pwm_ramp_ctrl #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_cfg_vld,
  input  logic [7:0]       host_cfg_channel,
  input  logic             host_cfg_en,
  input  logic [CNT_W-1:0] host_cfg_period,
  input  logic [CNT_W-1:0] host_cfg_hlevel,
  input  logic             ramp_start,
  input  logic             ramp_stop,
  input  logic [7:0]       ramp_channel,
  input  logic [CNT_W-1:0] ramp_period,
  input  logic [CNT_W-1:0] ramp_target,
  input  logic [CNT_W-1:0] ramp_step,
  input  logic [CNT_W-1:0] ramp_interval,
  output logic             pwm_config_vld,
  output logic [7:0]       pwm_config_channel,
  output logic             pwm_en,
  output logic [CNT_W-1:0] pwm_period,
  output logic [CNT_W-1:0] pwm_hlevel,
  output logic             ramp_busy,
  output logic             ramp_done,
  output logic             ramp_abort
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       ch_q, ch_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             bvld_q, bvld_d;
  logic [7:0]       bch_q, bch_d;
  logic             ben_q, ben_d;
  logic [CNT_W-1:0] bper_q, bper_d;
  logic [CNT_W-1:0] bhl_q, bhl_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] nxt;
  logic             abort_c;

  // The sum is formed one bit wider so a large step cannot wrap below the limit.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cur,
                                                input logic [CNT_W-1:0] step,
                                                input logic [CNT_W-1:0] lim);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= {1'b0, lim}) return lim;
    return sum[CNT_W-1:0];
  endfunction

  assign nxt     = sat_step(cur_q, step_q, target_q);
  assign abort_c = ramp_stop || (host_cfg_vld && (host_cfg_channel == ch_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      period_q   <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      cur_q      <= '0;
      tick_q     <= '0;
      bvld_q     <= 1'b0;
      bch_q      <= '0;
      ben_q      <= 1'b0;
      bper_q     <= '0;
      bhl_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      period_q   <= period_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      cur_q      <= cur_d;
      tick_q     <= tick_d;
      bvld_q     <= bvld_d;
      bch_q      <= bch_d;
      ben_q      <= ben_d;
      bper_q     <= bper_d;
      bhl_q      <= bhl_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    period_d   = period_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    cur_d      = cur_q;
    tick_d     = tick_q;
    abort_d    = 1'b0;
    bvld_d     = 1'b0;
    bch_d      = bch_q;
    ben_d      = ben_q;
    bper_d     = bper_q;
    bhl_d      = bhl_q;

    // Host writes own the bus in every state.
    if (host_cfg_vld) begin
      bvld_d = 1'b1;
      bch_d  = host_cfg_channel;
      ben_d  = host_cfg_en;
      bper_d = host_cfg_period;
      bhl_d  = host_cfg_hlevel;
    end

    case (state_q)
      ST_IDLE: begin
        if (ramp_start) begin
          ch_d       = ramp_channel;
          period_d   = ramp_period;
          target_d   = (ramp_target < ramp_period) ? ramp_target : ramp_period;
          step_d     = (ramp_step == '0) ? CNT_W'(1) : ramp_step;
          interval_d = ramp_interval;
          cur_d      = '0;
          tick_d     = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort_c) begin
          abort_d = 1'b1;
          tick_d  = '0;
          state_d = ST_IDLE;
        end else if (tick_q == interval_q) begin
          tick_d  = '0;
          state_d = ST_ISSUE;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        if (abort_c) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (!host_cfg_vld) begin
          bvld_d  = 1'b1;
          bch_d   = ch_q;
          ben_d   = 1'b1;
          bper_d  = period_q;
          bhl_d   = nxt;
          cur_d   = nxt;
          state_d = (nxt == target_q) ? ST_DONE : ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ramp_busy = (state_q == ST_WAIT) || (state_q == ST_ISSUE);
    ramp_done = (state_q == ST_DONE);
  end

  assign pwm_config_vld     = bvld_q;
  assign pwm_config_channel = bch_q;
  assign pwm_en             = ben_q;
  assign pwm_period         = bper_q;
  assign pwm_hlevel         = bhl_q;
  assign ramp_abort         = abort_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a scoreboard of expected bus writes (with their
// cycle numbers) is filled from stimulus tables and a ramp model, then drained by a monitor.
module tb_pwm_ramp_ctrl;
  localparam int W = 28;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         host_cfg_vld, host_cfg_en;
  logic [7:0]   host_cfg_channel;
  logic [W-1:0] host_cfg_period, host_cfg_hlevel;
  logic         ramp_start, ramp_stop;
  logic [7:0]   ramp_channel;
  logic [W-1:0] ramp_period, ramp_target, ramp_step, ramp_interval;
  logic         pwm_config_vld, pwm_en, ramp_busy, ramp_done, ramp_abort;
  logic [7:0]   pwm_config_channel;
  logic [W-1:0] pwm_period, pwm_hlevel;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_ramp_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_cfg_vld(host_cfg_vld), .host_cfg_channel(host_cfg_channel),
    .host_cfg_en(host_cfg_en), .host_cfg_period(host_cfg_period),
    .host_cfg_hlevel(host_cfg_hlevel),
    .ramp_start(ramp_start), .ramp_stop(ramp_stop), .ramp_channel(ramp_channel),
    .ramp_period(ramp_period), .ramp_target(ramp_target), .ramp_step(ramp_step),
    .ramp_interval(ramp_interval),
    .pwm_config_vld(pwm_config_vld), .pwm_config_channel(pwm_config_channel),
    .pwm_en(pwm_en), .pwm_period(pwm_period), .pwm_hlevel(pwm_hlevel),
    .ramp_busy(ramp_busy), .ramp_done(ramp_done), .ramp_abort(ramp_abort)
  );

  typedef struct {
    int           cyc;
    logic [7:0]   ch;
    logic         en;
    logic [W-1:0] per;
    logic [W-1:0] hl;
    logic         done;
  } wr_t;

  typedef struct {
    logic [7:0]   ch;
    logic         en;
    logic [W-1:0] per;
    logic [W-1:0] hl;
  } host_t;

  typedef struct {
    logic [7:0]   ch;
    logic [W-1:0] per;
    logic [W-1:0] tgt;
    logic [W-1:0] step;
    logic [W-1:0] iv;
    int           nwr;
    logic [W-1:0] fin;
  } ramp_t;

  wr_t          sbq[$];
  host_t        ht[4];
  ramp_t        rt[6];
  int           n_checks = 0;
  int           n_fail = 0;
  int           wr_count = 0;
  int           abort_cnt = 0;
  logic [W-1:0] last_hl = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step1();
  endtask

  // Expected ramp writes from the command fields, using wide integer arithmetic.
  task automatic push_ramp(input int first, input ramp_t r);
    longint t, s, cur, nxt;
    int c;
    t   = (longint'(r.tgt) < longint'(r.per)) ? longint'(r.tgt) : longint'(r.per);
    s   = (r.step == '0) ? 1 : longint'(r.step);
    cur = 0;
    c   = first;
    do begin
      nxt = cur + s;
      if (nxt >= t) nxt = t;
      sbq.push_back('{c, r.ch, 1'b1, r.per, W'(nxt), (nxt == t)});
      cur = nxt;
      c   = c + int'(r.iv) + 2;
    end while (nxt != t);
  endtask

  task automatic drive_start(input ramp_t r);
    ramp_channel  = r.ch;
    ramp_period   = r.per;
    ramp_target   = r.tgt;
    ramp_step     = r.step;
    ramp_interval = r.iv;
    ramp_start    = 1'b1;
    step1();
    ramp_start    = 1'b0;
  endtask

  task automatic host_wr(input logic [7:0] ch, input logic en,
                         input logic [W-1:0] per, input logic [W-1:0] hl);
    host_cfg_vld     = 1'b1;
    host_cfg_channel = ch;
    host_cfg_en      = en;
    host_cfg_period  = per;
    host_cfg_hlevel  = hl;
    step1();
    host_cfg_vld     = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((sbq.size() != 0 || ramp_busy || ramp_done) && n < budget) begin
      step1();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d writes still pending after %0d cycles, required 0", sbq.size(), budget);
      sbq.delete();
    end
  endtask

  task automatic run_ramp(input ramp_t r);
    int base, s;
    base = wr_count;
    s    = cyc;
    push_ramp(s + int'(r.iv) + 3, r);
    drive_start(r);
    @(negedge clk);
    chk("busy_after_start", ramp_busy, 1);
    step1();
    wait_quiet((int'(r.iv) + 2) * r.nwr + 20);
    chk("ramp_nwrites", wr_count - base, r.nwr);
    chk("ramp_final_hl", last_hl, r.fin);
    chk("busy_after_done", ramp_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, base, ab;
    rst_n = 1'b0;
    host_cfg_vld = 1'b0; host_cfg_channel = '0; host_cfg_en = 1'b0;
    host_cfg_period = '0; host_cfg_hlevel = '0;
    ramp_start = 1'b0; ramp_stop = 1'b0; ramp_channel = '0;
    ramp_period = '0; ramp_target = '0; ramp_step = '0; ramp_interval = '0;

    ht[0] = '{8'd5, 1'b1, 28'd1000, 28'd250};
    ht[1] = '{8'd0, 1'b0, 28'd0, 28'd0};
    ht[2] = '{8'd255, 1'b1, 28'hFFFFFFF, 28'hFFFFFFF};
    ht[3] = '{8'd12, 1'b0, 28'd777, 28'd12345};

    rt[0] = '{8'd3, 28'd1000, 28'd100, 28'd30, 28'd4, 4, 28'd100};
    rt[1] = '{8'd1, 28'd1000, 28'd2000, 28'd0, 28'd0, 1000, 28'd1000};
    rt[2] = '{8'd2, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF, 28'd1, 1, 28'hFFFFFFF};
    rt[3] = '{8'd2, 28'hFFFFFFF, 28'hFFFFFFF, 28'hA000000, 28'd2, 2, 28'hFFFFFFF};
    rt[4] = '{8'd4, 28'd500, 28'd0, 28'd10, 28'd2, 1, 28'd0};
    rt[5] = '{8'd8, 28'd300, 28'd250, 28'd100, 28'd0, 3, 28'd250};

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (ramp_abort) abort_cnt++;
          if (pwm_config_vld) begin
            wr_count++;
            last_hl = pwm_hlevel;
            if (sbq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_write: got ch %0d hlevel 0x%0h at cycle %0d, required no write",
                       pwm_config_channel, pwm_hlevel, cyc);
            end else begin
              wr_t e;
              e = sbq.pop_front();
              chk("wr_cycle", cyc, e.cyc);
              chk("wr_channel", pwm_config_channel, e.ch);
              chk("wr_en", pwm_en, e.en);
              chk("wr_period", pwm_period, e.per);
              chk("wr_hlevel", pwm_hlevel, e.hl);
              chk("wr_done", ramp_done, e.done);
            end
          end else begin
            chk("done_without_write", ramp_done, 0);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) step1();
    @(negedge clk);
    chk("rst_vld", pwm_config_vld, 0);
    chk("rst_channel", pwm_config_channel, 0);
    chk("rst_en", pwm_en, 0);
    chk("rst_period", pwm_period, 0);
    chk("rst_hlevel", pwm_hlevel, 0);
    chk("rst_busy", ramp_busy, 0);
    chk("rst_done", ramp_done, 0);
    chk("rst_abort", ramp_abort, 0);
    step1();
    rst_n = 1'b1;
    step1();

    // Back-to-back host passthrough
    for (int i = 0; i < 4; i++) begin
      sbq.push_back('{cyc + 1, ht[i].ch, ht[i].en, ht[i].per, ht[i].hl, 1'b0});
      host_cfg_vld     = 1'b1;
      host_cfg_channel = ht[i].ch;
      host_cfg_en      = ht[i].en;
      host_cfg_period  = ht[i].per;
      host_cfg_hlevel  = ht[i].hl;
      step1();
    end
    host_cfg_vld = 1'b0;
    repeat (3) step1();
    chk("passthrough_drained", sbq.size(), 0);

    for (int i = 0; i < 6; i++) run_ramp(rt[i]);

    // Collision: host ch 7 in the ISSUE cycle of a ch 3 ramp defers the ramp write
    ab = abort_cnt;
    s  = cyc;
    sbq.push_back('{s + 7, 8'd7, 1'b1, 28'd600, 28'd50, 1'b0});
    push_ramp(s + 8, rt[0]);
    drive_start(rt[0]);
    goto(s + 6);
    host_wr(8'd7, 1'b1, 28'd600, 28'd50);
    wait_quiet(60);
    chk("collision_no_abort", abort_cnt - ab, 0);

    // Abort by host write to the ramped channel during WAIT
    ab = abort_cnt;
    s  = cyc;
    sbq.push_back('{s + 7, 8'd3, 1'b1, 28'd1000, 28'd30, 1'b0});
    drive_start(rt[0]);
    goto(s + 9);
    sbq.push_back('{s + 10, 8'd3, 1'b0, 28'd1000, 28'd77, 1'b0});
    host_wr(8'd3, 1'b0, 28'd1000, 28'd77);
    goto(s + 10);
    @(negedge clk);
    chk("host_abort_pulse", ramp_abort, 1);
    chk("host_abort_busy", ramp_busy, 0);
    step1();
    @(negedge clk);
    chk("host_abort_one_cycle", ramp_abort, 0);
    repeat (30) step1();
    chk("host_abort_drained", sbq.size(), 0);
    chk("host_abort_count", abort_cnt - ab, 1);

    // ramp_stop during WAIT
    ab   = abort_cnt;
    base = wr_count;
    s    = cyc;
    drive_start(rt[0]);
    goto(s + 3);
    ramp_stop = 1'b1;
    step1();
    ramp_stop = 1'b0;
    @(negedge clk);
    chk("stop_abort_pulse", ramp_abort, 1);
    chk("stop_abort_busy", ramp_busy, 0);
    repeat (20) step1();
    chk("stop_no_writes", wr_count - base, 0);
    chk("stop_abort_count", abort_cnt - ab, 1);

    // ramp_start while busy is ignored
    base = wr_count;
    s    = cyc;
    push_ramp(s + 7, rt[0]);
    drive_start(rt[0]);
    goto(s + 3);
    drive_start(rt[5]);
    wait_quiet(60);
    chk("busy_start_nwrites", wr_count - base, 4);
    chk("busy_start_final", last_hl, 100);

    // Reset mid-ramp after two writes, then a fresh ramp
    s = cyc;
    push_ramp(s + 6, '{8'd6, 28'd1000, 28'd100, 28'd10, 28'd3, 10, 28'd100});
    drive_start('{8'd6, 28'd1000, 28'd100, 28'd10, 28'd3, 10, 28'd100});
    goto(s + 13);
    chk("pre_reset_writes", sbq.size(), 8);
    rst_n = 1'b0;
    #2;
    chk("midrst_vld", pwm_config_vld, 0);
    chk("midrst_channel", pwm_config_channel, 0);
    chk("midrst_en", pwm_en, 0);
    chk("midrst_period", pwm_period, 0);
    chk("midrst_hlevel", pwm_hlevel, 0);
    chk("midrst_busy", ramp_busy, 0);
    chk("midrst_done", ramp_done, 0);
    chk("midrst_abort", ramp_abort, 0);
    sbq.delete();
    repeat (2) step1();
    rst_n = 1'b1;
    repeat (10) step1();
    run_ramp(rt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
